// File: rtl/hazard_sched_if.sv
// Decode-side bundle between the RV32I core and the hazard scheduler:
// ID instruction fields, branch/DRAM status in, stall/flush/forward controls out.
interface hazard_sched_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_we_reg;
  logic       id_isLoad;
  logic       id_we_dram;
  logic       id_valid;
  logic       ex_br_flush;
  logic       dram_ack;

  logic       pc_stall;
  logic       ifid_stall;
  logic       idex_stall;
  logic       exmem_stall;
  logic       memwb_stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic [1:0] fwd_rs1_sel;
  logic [1:0] fwd_rs2_sel;
  logic       dram_req;
  logic       mem_err;
  logic       dbg_state;  // 0 = RUN, 1 = MEMWAIT

  // Handshake: dram_req is a level held while the MEM stage owns a load/store;
  // the access completes in the first cycle dram_ack is seen with dram_req high
  // (or on wait timeout), and the pipe is frozen in every cycle before that.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we_reg,
           id_isLoad, id_we_dram, id_valid, ex_br_flush, dram_ack,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
           ifid_flush, idex_flush, fwd_rs1_sel, fwd_rs2_sel, dram_req,
           mem_err, dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we_reg,
           id_isLoad, id_we_dram, id_valid, ex_br_flush, dram_ack,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
           ifid_flush, idex_flush, fwd_rs1_sel, fwd_rs2_sel, dram_req,
           mem_err, dbg_state
  );
endinterface

// File: rtl/hazard_sched.sv
// Hazard/stall scheduler for the five-stage RV32I pipe: shadow EX/MEM/WB
// destination tracking, forwarding selects, load-use bubbles and DRAM wait freeze.
module hazard_sched #(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic           cpu_clk,
  input logic           cpu_rstn,
  hazard_sched_if.slave bus
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
    logic       mem;
  } shadow_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  shadow_t    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;

  logic [1:0] fwd1, fwd2;
  logic       load_use, req, freeze, timeout;

  function automatic logic writes(shadow_t e, logic [4:0] rs);
    return e.valid & e.we & (e.rd == rs) & (rs != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(logic used, logic [4:0] rs,
                                         shadow_t ex, shadow_t mem, shadow_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (writes(ex, rs))       sel = 2'b01;
      else if (writes(mem, rs)) sel = 2'b10;
      else if (writes(wb, rs))  sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    fwd1     = fwd_sel(bus.id_rs1_used, bus.id_rs1, ex_q, mem_q, wb_q);
    fwd2     = fwd_sel(bus.id_rs2_used, bus.id_rs2, ex_q, mem_q, wb_q);
    load_use = ex_q.valid & ex_q.load &
               ((bus.id_rs1_used & writes(ex_q, bus.id_rs1)) |
                (bus.id_rs2_used & writes(ex_q, bus.id_rs2)));
    req      = mem_q.valid & mem_q.mem;
    timeout  = (state_q == MEMWAIT) & ~bus.dram_ack & (cnt_q >= WAIT_MAX);
    freeze   = ((state_q == RUN) & req & ~bus.dram_ack) |
               ((state_q == MEMWAIT) & ~bus.dram_ack & (cnt_q < WAIT_MAX));
  end

  // Priority: memory freeze, then branch flush, then load-use bubble.
  always_comb begin
    bus.pc_stall    = 1'b0;
    bus.ifid_stall  = 1'b0;
    bus.idex_stall  = 1'b0;
    bus.exmem_stall = 1'b0;
    bus.memwb_stall = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    if (freeze) begin
      bus.pc_stall    = 1'b1;
      bus.ifid_stall  = 1'b1;
      bus.idex_stall  = 1'b1;
      bus.exmem_stall = 1'b1;
      bus.memwb_stall = 1'b1;
    end else if (bus.ex_br_flush) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_stall   = 1'b1;
      bus.ifid_stall = 1'b1;
      bus.idex_flush = 1'b1;
    end
  end

  assign bus.fwd_rs1_sel = fwd1;
  assign bus.fwd_rs2_sel = fwd2;
  assign bus.dram_req    = req;
  assign bus.mem_err     = mem_err_q;
  assign bus.dbg_state   = state_q;

  // The counter includes the RUN cycle that first saw the missing ack, so a
  // timeout yields exactly MEM_WAIT_MAX freeze cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = 8'd0;
    mem_err_d = mem_err_q | timeout;
    case (state_q)
      RUN: begin
        if (req & ~bus.dram_ack) begin
          state_d = MEMWAIT;
          cnt_d   = 8'd1;
        end
      end
      MEMWAIT: begin
        if (bus.dram_ack | timeout) state_d = RUN;
        else                        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bus.ex_br_flush | load_use) begin
        ex_d = '0;
      end else begin
        ex_d = '{valid: bus.id_valid, rd: bus.id_rd, we: bus.id_we_reg,
                 load: bus.id_isLoad, mem: bus.id_isLoad | bus.id_we_dram};
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      state_q   <= RUN;
      cnt_q     <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed plus randomized bench for hazard_sched, checked cycle by cycle
// against an instruction-level pipeline model.
module tb_hazard_sched;
  localparam int MAX = 4;

  logic cpu_clk;
  logic cpu_rstn;
  int   checks = 0;
  int   errors = 0;

  hazard_sched_if bus();

  hazard_sched #(.MEM_WAIT_MAX(MAX)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rstn(cpu_rstn),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; waited = freeze cycles spent
  // on the access currently sitting in MEM.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
    logic       store;
  } instr_t;

  instr_t pipe[3];
  int     waited;
  logic   err;
  logic   e_req, e_frz, e_lu, e_fl;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    waited = 0;
    err    = 1'b0;
  endtask

  function automatic logic [1:0] m_fwd(logic used, logic [4:0] rs);
    if (!used || rs == 5'd0) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (pipe[i].valid && pipe[i].we && pipe[i].rd == rs) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic model_eval();
    e_req = pipe[1].valid && (pipe[1].load || pipe[1].store);
    e_frz = e_req && !bus.dram_ack && (waited < MAX);
    e_lu  = pipe[0].load && (m_fwd(bus.id_rs1_used, bus.id_rs1) == 2'd1 ||
                             m_fwd(bus.id_rs2_used, bus.id_rs2) == 2'd1);
    e_fl  = bus.ex_br_flush;
  endtask

  task automatic model_advance();
    if (e_frz) begin
      waited++;
    end else begin
      if (e_req && !bus.dram_ack && waited >= MAX) err = 1'b1;
      waited  = 0;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (e_fl || e_lu) pipe[0] = '0;
      else pipe[0] = '{valid: bus.id_valid, rd: bus.id_rd, we: bus.id_we_reg,
                       load: bus.id_isLoad, store: bus.id_we_dram};
    end
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    model_eval();
    check("pc_stall",    8'(bus.pc_stall),    8'(e_frz || (!e_fl && e_lu)));
    check("ifid_stall",  8'(bus.ifid_stall),  8'(e_frz || (!e_fl && e_lu)));
    check("idex_stall",  8'(bus.idex_stall),  8'(e_frz));
    check("exmem_stall", 8'(bus.exmem_stall), 8'(e_frz));
    check("memwb_stall", 8'(bus.memwb_stall), 8'(e_frz));
    check("ifid_flush",  8'(bus.ifid_flush),  8'(!e_frz && e_fl));
    check("idex_flush",  8'(bus.idex_flush),  8'(!e_frz && (e_fl || e_lu)));
    check("fwd_rs1_sel", 8'(bus.fwd_rs1_sel), 8'(m_fwd(bus.id_rs1_used, bus.id_rs1)));
    check("fwd_rs2_sel", 8'(bus.fwd_rs2_sel), 8'(m_fwd(bus.id_rs2_used, bus.id_rs2)));
    check("dram_req",    8'(bus.dram_req),    8'(e_req));
    check("mem_err",     8'(bus.mem_err),     8'(err));
  endtask

  // Called just after a rising edge; checks mid-cycle then advances one clock.
  task automatic tick();
    #2;
    check_outputs();
    @(posedge cpu_clk);
    if (cpu_rstn) model_advance();
    #1;
  endtask

  task automatic set_id(bit v, logic [4:0] rd, bit we, bit ld, bit st,
                        logic [4:0] r1, bit u1, logic [4:0] r2, bit u2);
    bus.id_valid    = v;
    bus.id_rd       = rd;
    bus.id_we_reg   = we;
    bus.id_isLoad   = ld;
    bus.id_we_dram  = st;
    bus.id_rs1      = r1;
    bus.id_rs1_used = u1;
    bus.id_rs2      = r2;
    bus.id_rs2_used = u2;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cpu_rstn        = 1'b0;
    bus.ex_br_flush = 1'b0;
    bus.dram_ack    = 1'b1;
    idle();
    model_reset();
    #3;
    check_outputs();
    check("reset_fwd1", 8'(bus.fwd_rs1_sel), 8'd0);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(posedge cpu_clk);
    #1;

    // EX forwarding, then WB forwarding across two independent instructions
    set_id(1, 5, 1, 0, 0, 2, 1, 3, 1); tick();
    set_id(1, 7, 1, 0, 0, 5, 1, 1, 1); #2;
    check("fwd_ex", 8'(bus.fwd_rs1_sel), 8'd1);
    tick();
    set_id(1, 5, 1, 0, 0, 2, 1, 3, 1); tick();
    set_id(1, 8, 1, 0, 0, 2, 1, 3, 1); tick();
    set_id(1, 9, 1, 0, 0, 2, 1, 3, 1); tick();
    set_id(1, 7, 1, 0, 0, 5, 1, 1, 1); #2;
    check("fwd_wb", 8'(bus.fwd_rs1_sel), 8'd3);
    tick();

    // Load-use: one bubble, then MEM forwarding
    set_id(1, 6, 1, 1, 0, 2, 1, 0, 0); tick();
    set_id(1, 7, 1, 0, 0, 6, 1, 6, 1); #2;
    check("lu_pc_stall", 8'(bus.pc_stall), 8'd1);
    check("lu_ifid_stall", 8'(bus.ifid_stall), 8'd1);
    check("lu_idex_flush", 8'(bus.idex_flush), 8'd1);
    tick(); #2;
    check("lu_fwd1_mem", 8'(bus.fwd_rs1_sel), 8'd2);
    check("lu_fwd2_mem", 8'(bus.fwd_rs2_sel), 8'd2);
    check("lu_no_stall", 8'(bus.pc_stall), 8'd0);
    tick();

    // x0 is never a forwarding source nor a load-use hazard
    set_id(1, 0, 1, 1, 0, 2, 1, 0, 0); tick();
    set_id(1, 7, 1, 0, 0, 0, 1, 0, 1); #2;
    check("x0_fwd1", 8'(bus.fwd_rs1_sel), 8'd0);
    check("x0_no_stall", 8'(bus.pc_stall), 8'd0);
    tick();

    // Branch flush overrides load-use and bubbles EX
    set_id(1, 6, 1, 1, 0, 2, 1, 0, 0); tick();
    set_id(1, 7, 1, 0, 0, 6, 1, 1, 1);
    bus.ex_br_flush = 1'b1; #2;
    check("br_ifid_flush", 8'(bus.ifid_flush), 8'd1);
    check("br_idex_flush", 8'(bus.idex_flush), 8'd1);
    check("br_no_stall", 8'(bus.pc_stall), 8'd0);
    tick();
    bus.ex_br_flush = 1'b0; #2;
    check("br_ex_bubble", 8'(bus.fwd_rs1_sel), 8'd2);
    tick();
    idle(); tick(); tick(); tick();

    // Store with ack delayed three cycles
    set_id(1, 0, 0, 0, 1, 2, 1, 3, 1); tick();
    idle(); bus.dram_ack = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      #2;
      check("sw_wait_stall", 8'(bus.memwb_stall), 8'd1);
      check("sw_wait_req", 8'(bus.dram_req), 8'd1);
      tick();
    end
    bus.dram_ack = 1'b1; #2;
    check("sw_release", 8'(bus.pc_stall), 8'd0);
    check("sw_req_at_ack", 8'(bus.dram_req), 8'd1);
    tick(); #2;
    check("sw_no_err", 8'(bus.mem_err), 8'd0);
    tick();

    // Timeout: no ack ever arrives
    set_id(1, 3, 1, 1, 0, 2, 1, 0, 0); tick();
    idle(); bus.dram_ack = 1'b0; tick();
    for (int i = 0; i < MAX; i++) begin
      #2;
      check("to_freeze", 8'(bus.pc_stall), 8'd1);
      tick();
    end
    #2;
    check("to_release", 8'(bus.pc_stall), 8'd0);
    tick(); #2;
    check("to_err_set", 8'(bus.mem_err), 8'd1);
    bus.dram_ack = 1'b1;
    tick(); tick(); #2;
    check("to_err_sticky", 8'(bus.mem_err), 8'd1);
    tick();

    // Asynchronous reset in the middle of a memory wait
    set_id(1, 0, 0, 0, 1, 2, 1, 3, 1); tick();
    idle(); bus.dram_ack = 1'b0; tick(); tick();
    #1;
    cpu_rstn = 1'b0;
    #1;
    model_reset();
    check("rst_pc_stall", 8'(bus.pc_stall), 8'd0);
    check("rst_dram_req", 8'(bus.dram_req), 8'd0);
    check("rst_mem_err", 8'(bus.mem_err), 8'd0);
    check_outputs();
    bus.dram_ack = 1'b1;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(posedge cpu_clk);
    #1;

    // Randomized traffic
    repeat (400) begin
      int kind;
      kind = $urandom_range(0, 3);
      set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)),
             kind != 1, kind == 0, kind == 1,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      bus.ex_br_flush = ($urandom_range(0, 7) == 0);
      bus.dram_ack    = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
